qsort_wb: RTL and testbench

Downstream write-back stage for the 10-word sorting engine. It consumes the engine's sorted AXI-Stream output and writes each word to consecutive word addresses through a simple memory write port. A one-cycle done pulse marks completion of each frame. It sits between the sorter's `sm_*` stream and the user-area memory/DMA arbiter, and is started by the same DMA control that starts the sorter.

---
 rtl/qsort_pkg.sv | 15 +
 rtl/qsort_wb_slot.sv | 34 +++
 rtl/qsort_wb.sv | 131 +++++++++++++
 tb/tb_qsort_wb.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsort_pkg.sv
// Shared types and constants for the sorter write-back path (qsort_wb).
package qsort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } qsort_state_t;

  localparam int QSORT_WORD_BYTES  = 4;
  localparam int QSORT_LEN_DEFAULT = 10;

  typedef logic [5:0] qsort_cnt_t;

endpackage

// File: rtl/qsort_wb_slot.sv
// One-entry holding register between the sorted stream and the memory write port.
// A load takes priority over an ack so that ack+accept keeps the slot full.
module qsort_wb_slot
  import qsort_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   load,
  input  logic [pDATA_WIDTH-1:0] load_data,
  input  logic [pADDR_WIDTH-1:0] load_addr,
  input  logic                   wr_ack,
  output logic                   slot_valid,
  output logic [pDATA_WIDTH-1:0] slot_data,
  output logic [pADDR_WIDTH-1:0] slot_addr
);

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      slot_valid <= 1'b0;
      slot_data  <= '0;
      slot_addr  <= '0;
    end else if (load) begin
      slot_valid <= 1'b1;
      slot_data  <= load_data;
      slot_addr  <= load_addr;
    end else if (wr_ack) begin
      slot_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/qsort_wb.sv
// Write-back stage: stores each sorted frame word to base + 4*index, pulses dma_done at the end.
// Optional unsigned ascending-order check enabled by defining QSORT_WB_ORDER_CHECK_EN.
module qsort_wb
  import qsort_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pLEN        = QSORT_LEN_DEFAULT
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   dma_start,
  input  logic [pADDR_WIDTH-1:0] dma_base_addr,
  output logic                   dma_busy,
  output logic                   dma_done,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tready,
  output logic                   mem_wr_en,
  output logic [pADDR_WIDTH-1:0] mem_wr_addr,
  output logic [pDATA_WIDTH-1:0] mem_wr_data,
  input  logic                   mem_wr_ack,
  output logic                   order_err
);

  localparam qsort_cnt_t LEN_C = qsort_cnt_t'(pLEN);

  qsort_state_t           state_reg;
  qsort_cnt_t             acc_cnt_reg;
  qsort_cnt_t             wr_cnt_reg;
  logic [pADDR_WIDTH-1:0] base_reg;
  logic                   busy_reg;
  logic                   done_reg;

  logic                   slot_valid;
  logic [pDATA_WIDTH-1:0] slot_data;
  logic [pADDR_WIDTH-1:0] slot_addr;

  logic                   accept;
  logic                   wr_fire;
  logic                   last_wr;
  logic [pADDR_WIDTH-1:0] acc_addr;

  // Ack frees the slot in the same cycle, so ready follows ack combinationally.
  assign ss_tready = (state_reg == RUN) && (acc_cnt_reg < LEN_C) &&
                     (!slot_valid || mem_wr_ack);
  assign accept    = ss_tvalid && ss_tready;
  assign wr_fire   = slot_valid && mem_wr_ack;
  assign last_wr   = wr_fire && (wr_cnt_reg == LEN_C - 6'd1);
  assign acc_addr  = base_reg +
                     pADDR_WIDTH'(acc_cnt_reg) * pADDR_WIDTH'(QSORT_WORD_BYTES);

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state_reg   <= IDLE;
      acc_cnt_reg <= '0;
      wr_cnt_reg  <= '0;
      base_reg    <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (dma_start) begin
            state_reg   <= RUN;
            base_reg    <= dma_base_addr;
            acc_cnt_reg <= '0;
            wr_cnt_reg  <= '0;
            busy_reg    <= 1'b1;
          end
        end
        RUN: begin
          if (accept)  acc_cnt_reg <= acc_cnt_reg + 6'd1;
          if (wr_fire) wr_cnt_reg  <= wr_cnt_reg + 6'd1;
          if (last_wr) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  qsort_wb_slot #(
    .pADDR_WIDTH (pADDR_WIDTH),
    .pDATA_WIDTH (pDATA_WIDTH)
  ) u_slot (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .load       (accept),
    .load_data  (ss_tdata),
    .load_addr  (acc_addr),
    .wr_ack     (mem_wr_ack),
    .slot_valid (slot_valid),
    .slot_data  (slot_data),
    .slot_addr  (slot_addr)
  );

  assign mem_wr_en   = slot_valid;
  assign mem_wr_addr = slot_addr;
  assign mem_wr_data = slot_data;
  assign dma_busy    = busy_reg;
  assign dma_done    = done_reg;

`ifdef QSORT_WB_ORDER_CHECK_EN
  logic [pDATA_WIDTH-1:0] prev_word_reg;
  logic                   order_err_reg;

  // The first word of a frame (acc_cnt 0) has no predecessor to compare with.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      prev_word_reg <= '0;
      order_err_reg <= 1'b0;
    end else if (state_reg == IDLE && dma_start) begin
      order_err_reg <= 1'b0;
    end else if (accept) begin
      prev_word_reg <= ss_tdata;
      if (acc_cnt_reg != '0 && ss_tdata < prev_word_reg) order_err_reg <= 1'b1;
    end
  end

  assign order_err = order_err_reg;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_qsort_wb.sv
// Scoreboard bench for qsort_wb: driver issues frames and pushes expected writes, monitor checks them.
module tb_qsort_wb;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int LEN = 10;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n = 1'b0;
  logic          dma_start = 1'b0;
  logic [AW-1:0] dma_base_addr = '0;
  logic          dma_busy;
  logic          dma_done;
  logic          ss_tvalid = 1'b0;
  logic [DW-1:0] ss_tdata = '0;
  logic          ss_tready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_wr_ack = 1'b0;
  logic          order_err;

  always #5 axis_clk = ~axis_clk;

  qsort_wb #(
    .pADDR_WIDTH (AW),
    .pDATA_WIDTH (DW),
    .pLEN        (LEN)
  ) dut (
    .axis_clk      (axis_clk),
    .axis_rst_n    (axis_rst_n),
    .dma_start     (dma_start),
    .dma_base_addr (dma_base_addr),
    .dma_busy      (dma_busy),
    .dma_done      (dma_done),
    .ss_tvalid     (ss_tvalid),
    .ss_tdata      (ss_tdata),
    .ss_tready     (ss_tready),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_ack    (mem_wr_ack),
    .order_err     (order_err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] src_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            ack_mode = 0;
  int            cyc = 0;
  int            acc_n = 0;
  int            wr_seen = 0;
  int            done_cyc = 0;
  int            start_cyc = 0;
  bit            mon_en = 1'b0;
  bit            done_due = 1'b0;
  bit            done_seen = 1'b0;
  bit            exp_oe = 1'b0;
  bit            exp_oe_nxt = 1'b0;
  logic [DW-1:0] last_word = '0;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // One clock: drive at the falling edge, observe the handshake 1 time unit later.
  task automatic step(input bit start);
    @(negedge axis_clk);
    cyc++;
    exp_oe    = exp_oe_nxt;
    dma_start = start;
    case (ack_mode)
      0:       mem_wr_ack = 1'b1;
      1:       mem_wr_ack = (cyc % 3 == 0);
      default: mem_wr_ack = 1'($urandom_range(0, 1));
    endcase
    ss_tvalid = (src_q.size() > 0);
    ss_tdata  = ss_tvalid ? src_q[0] : $urandom;
    #1;
    if (acc_n >= LEN) check("tready_after_len", ss_tready, 0);
    if (ss_tvalid && ss_tready && axis_rst_n) begin
`ifdef QSORT_WB_ORDER_CHECK_EN
      if (acc_n > 0 && src_q[0] < last_word) exp_oe_nxt = 1'b1;
`endif
      last_word = src_q[0];
      acc_n++;
      void'(src_q.pop_front());
    end
  endtask

  task automatic start_frame(input logic [AW-1:0] base, input int mode);
    ack_mode = mode;
    for (int i = 0; i < LEN; i++) begin
      wr_t w;
      w.addr = base + AW'(4 * i);
      w.data = src_q[i];
      exp_q.push_back(w);
    end
    acc_n      = 0;
    wr_seen    = 0;
    done_seen  = 1'b0;
    exp_oe_nxt = 1'b0;
    dma_base_addr = base;
    step(1'b1);
    start_cyc = cyc;
    $display("frame start base=0x%03h ack_mode=%0d", base, mode);
    step(1'b0);
    check("busy_after_start", dma_busy, 1);
    dma_base_addr = AW'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_seen && n < 300) begin
      step(1'b0);
      #3;
      n++;
    end
    check("done_reached", done_seen, 1);
    check("writes_left", exp_q.size(), 0);
  endtask

  task automatic load_random(input int count, input bit ascending);
    logic [DW-1:0] v = '0;
    src_q.delete();
    for (int i = 0; i < count; i++) begin
      v = ascending ? v + DW'($urandom_range(0, 1000)) : DW'($urandom);
      src_q.push_back(v);
    end
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_busy"}, dma_busy, 0);
    check({tag, "_done"}, dma_done, 0);
    check({tag, "_tready"}, ss_tready, 0);
    check({tag, "_wr_en"}, mem_wr_en, 0);
    check({tag, "_wr_addr"}, mem_wr_addr, 0);
    check({tag, "_wr_data"}, mem_wr_data, 0);
    check({tag, "_order_err"}, order_err, 0);
  endtask

  // Monitor: checks every DUT output cycle against the scoreboard and the spec rules.
  initial begin
    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;
    wr_t           w;
    forever begin
      @(negedge axis_clk);
      #2;
      if (!mon_en) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("stall_wr_en", mem_wr_en, 1);
        check("stall_addr", mem_wr_addr, prev_addr);
        check("stall_data", mem_wr_data, prev_data);
      end
      if (mem_wr_en && !mem_wr_ack) check("tready_when_full", ss_tready, 0);
      check("order_err", order_err, exp_oe);
      check("dma_done", dma_done, done_due);
      if (done_due) begin
        check("busy_at_done", dma_busy, 0);
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      done_due = 1'b0;
      if (mem_wr_en && mem_wr_ack) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, expected none", mem_wr_addr, mem_wr_data);
        end else begin
          w = exp_q.pop_front();
          $display("write addr=0x%03h data=0x%08h (expected 0x%03h 0x%08h)", mem_wr_addr, mem_wr_data, w.addr, w.data);
          check("wr_addr", mem_wr_addr, w.addr);
          check("wr_data", mem_wr_data, w.data);
          wr_seen++;
          if (wr_seen == LEN) done_due = 1'b1;
        end
      end
      prev_stall = mem_wr_en && !mem_wr_ack;
      prev_addr  = mem_wr_addr;
      prev_data  = mem_wr_data;
    end
  end

  initial begin
    int n;
    repeat (3) step(1'b0);
    check_all_zero("reset");
    axis_rst_n = 1'b1;
    mon_en = 1'b1;
    step(1'b0);

    // Zero-wait memory, data 1..10 at 0x100, done exactly 12 cycles after start.
    src_q.delete();
    for (int i = 1; i <= LEN; i++) src_q.push_back(DW'(i));
    start_frame(12'h100, 0);
    wait_done();
    check("latency", done_cyc - start_cyc, 12);

    // Ack every third cycle: stalls must hold address/data.
    load_random(LEN, 1'b1);
    start_frame(12'h080, 1);
    wait_done();

    // Address wrap past the top of the 12-bit space.
    load_random(LEN, 1'b1);
    start_frame(12'hFF8, 2);
    wait_done();

    // Stream keeps offering words and a stray start arrives mid-frame.
    load_random(LEN + 2, 1'b1);
    start_frame(12'h200, 2);
    repeat (3) step(1'b0);
    dma_base_addr = 12'h7A0;
    step(1'b1);
    $display("mid-frame dma_start pulsed");
    wait_done();
    repeat (3) step(1'b0);
    check("accepted_count", acc_n, LEN);
    check("words_left", src_q.size(), 2);
    src_q.delete();

    // Reset right after the 4th write, then a clean frame from base+0.
    load_random(LEN, 1'b1);
    start_frame(12'h300, 0);
    n = 0;
    while (wr_seen < 4 && n < 100) begin
      step(1'b0);
      #3;
      n++;
    end
    check("reached_4th_write", wr_seen, 4);
    mon_en = 1'b0;
    axis_rst_n = 1'b0;
    step(1'b0);
    check_all_zero("midreset");
    $display("mid-frame reset applied");
    exp_q.delete();
    src_q.delete();
    acc_n = 0;
    wr_seen = 0;
    done_due = 1'b0;
    exp_oe = 1'b0;
    exp_oe_nxt = 1'b0;
    axis_rst_n = 1'b1;
    mon_en = 1'b1;
    load_random(LEN, 1'b1);
    start_frame(12'h300, 0);
    wait_done();
    check("latency_after_reset", done_cyc - start_cyc, 12);

    // Out-of-order input 1,2,5,3,...
    src_q.delete();
    src_q.push_back(32'd1);
    src_q.push_back(32'd2);
    src_q.push_back(32'd5);
    src_q.push_back(32'd3);
    for (int i = 4; i < LEN; i++) src_q.push_back(DW'(i + 2));
    start_frame(12'h040, 0);
    wait_done();
`ifdef QSORT_WB_ORDER_CHECK_EN
    check("order_err_sticky", order_err, 1);
`endif

    // Randomised frames; the next start also clears any order flag.
    for (int f = 0; f < 4; f++) begin
      load_random(LEN, f[0]);
      start_frame(AW'($urandom), $urandom_range(0, 2));
      wait_done();
    end

    repeat (3) step(1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
